bus_mux_arb: RTL and testbench

- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of N_SRC source words onto the shared datapath bus.
- Two source-selection modes:
  - explicit: encoded select driven by the control unit.
  - arbitrated: round-robin among requesting sources, with optional bus lock.
- Output is registered, so the bus holds a stable value for a full cycle and never becomes a latch.

---
 rtl/bus_mux_arb_if.sv | 29 ++
 rtl/bus_mux_arb.sv | 119 +++++++++++
 tb/tb_bus_mux_arb.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bus_mux_arb_if.sv
// Signal bundle between the control unit (master) and the registered bus multiplexer (slave).
// Handshake: a source is taken only when the mux reports it; bus_valid=1 means bus_contents was loaded at the last edge.
interface bus_mux_arb_if #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 25,
  parameter int SEL_W = 5
);
  logic                   mode;
  logic [SEL_W-1:0]       select;
  logic                   sel_valid;
  logic [N_SRC-1:0]       req;
  logic                   lock;
  logic [N_SRC*WIDTH-1:0] data_in;
  logic [WIDTH-1:0]       bus_contents;
  logic                   bus_valid;
  logic [N_SRC-1:0]       grant;
  logic [SEL_W-1:0]       src_idx;
  logic                   sel_err;

  modport master (
    output mode, select, sel_valid, req, lock, data_in,
    input  bus_contents, bus_valid, grant, src_idx, sel_err
  );

  modport slave (
    input  mode, select, sel_valid, req, lock, data_in,
    output bus_contents, bus_valid, grant, src_idx, sel_err
  );
endinterface

// File: rtl/bus_mux_arb.sv
// Registered N-source bus multiplexer: explicit encoded select, or round-robin arbitration with bus lock.
// Arbiter state is exported on state_dbg (0 = IDLE, 1 = OWNED).
module bus_mux_arb #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 25,
  parameter int SEL_W = 5
) (
  input  logic         clk,
  input  logic         clr,
  bus_mux_arb_if.slave io,
  output logic         state_dbg
);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_e;

  arb_state_e       state, next_state;
  logic [SEL_W-1:0] rr_ptr, rr_next;

  logic             load;
  logic [SEL_W-1:0] load_idx;
  logic             err;
  logic [WIDTH-1:0] load_word;
  logic [N_SRC-1:0] load_onehot;

  logic             found;
  logic [SEL_W-1:0] win;
  logic             owner_req;

  assign state_dbg = state;

  // Rotating priority search starting at rr_ptr, wrapping N_SRC-1 -> 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && io.req[idx]) begin
        found = 1'b1;
        win   = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (SEL_W'(i) == io.src_idx) owner_req = io.req[i];
    end
  end

  always_comb begin
    next_state = state;
    rr_next    = rr_ptr;
    load       = 1'b0;
    load_idx   = io.src_idx;
    err        = 1'b0;
    if (!io.mode) begin
      // Explicit mode never owns the bus across cycles; leaving arbitration drops ownership.
      next_state = IDLE;
      if (io.sel_valid) begin
        if (int'(io.select) < N_SRC) begin
          load     = 1'b1;
          load_idx = io.select;
        end else begin
          err = 1'b1;
        end
      end
    end else begin
      if (state == OWNED && io.lock && owner_req) begin
        load       = 1'b1;
        load_idx   = io.src_idx;
        next_state = OWNED;
      end else if (found) begin
        load       = 1'b1;
        load_idx   = win;
        rr_next    = (int'(win) == N_SRC - 1) ? '0 : win + SEL_W'(1);
        next_state = OWNED;
      end else begin
        next_state = IDLE;
      end
    end
  end

  always_comb begin
    load_word   = '0;
    load_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (SEL_W'(i) == load_idx) begin
        load_word      = io.data_in[i*WIDTH +: WIDTH];
        load_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      io.bus_contents <= '0;
      io.bus_valid    <= 1'b0;
      io.grant        <= '0;
      io.src_idx      <= '0;
      io.sel_err      <= 1'b0;
    end else begin
      state        <= next_state;
      rr_ptr       <= rr_next;
      io.bus_valid <= load;
      io.sel_err   <= err;
      io.grant     <= load ? load_onehot : '0;
      if (load) begin
        io.bus_contents <= load_word;
        io.src_idx      <= load_idx;
      end
    end
  end

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed bench for bus_mux_arb: reset, explicit select and range errors, round-robin wrap, lock, reset mid-lock.
module tb_bus_mux_arb;
  localparam int WIDTH = 32;
  localparam int N_SRC = 25;
  localparam int SEL_W = 5;

  logic clk;
  logic clr;
  logic state_dbg;
  int   checks;
  int   errors;

  bus_mux_arb_if #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W)) io ();

  bus_mux_arb #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .io        (io),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [WIDTH-1:0] v);
    io.data_in[i*WIDTH +: WIDTH] = v;
  endtask

  function automatic logic [N_SRC-1:0] onehot(input int k);
    logic [N_SRC-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic check_bus(input string tag, input logic [WIDTH-1:0] exp_data, input logic exp_valid,
                           input logic [N_SRC-1:0] exp_grant, input logic [SEL_W-1:0] exp_idx);
    check({tag, ".data"},  64'(io.bus_contents), 64'(exp_data));
    check({tag, ".valid"}, 64'(io.bus_valid),    64'(exp_valid));
    check({tag, ".grant"}, 64'(io.grant),        64'(exp_grant));
    check({tag, ".idx"},   64'(io.src_idx),      64'(exp_idx));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    clr          = 1'b1;
    io.mode      = 1'b1;
    io.select    = '0;
    io.sel_valid = 1'b0;
    io.req       = '1;
    io.lock      = 1'b0;
    for (int i = 0; i < N_SRC; i++) set_word(i, 32'hA000_0000 + 32'(i));

    // Reset held two cycles with every source requesting.
    step();
    step();
    check_bus("reset", 32'h0, 1'b0, '0, 5'd0);
    check("reset.sel_err", 64'(io.sel_err), 64'd0);
    check("reset.state", 64'(state_dbg), 64'd0);

    clr = 1'b0;
    step();
    check_bus("post_reset", 32'hA000_0000, 1'b1, onehot(0), 5'd0);
    check("post_reset.state", 64'(state_dbg), 64'd1);

    // Explicit select; leaving arbitration drops the FSM to IDLE.
    io.mode      = 1'b0;
    io.sel_valid = 1'b1;
    io.select    = 5'd7;
    step();
    check_bus("explicit7", 32'hA000_0007, 1'b1, onehot(7), 5'd7);
    check("explicit7.sel_err", 64'(io.sel_err), 64'd0);
    check("explicit7.state", 64'(state_dbg), 64'd0);

    io.select = 5'd27;
    step();
    check_bus("sel27", 32'hA000_0007, 1'b0, '0, 5'd7);
    check("sel27.sel_err", 64'(io.sel_err), 64'd1);

    io.sel_valid = 1'b0;
    step();
    check_bus("no_sel", 32'hA000_0007, 1'b0, '0, 5'd7);
    check("no_sel.sel_err", 64'(io.sel_err), 64'd0);

    // Range boundary: last legal index, then first illegal one.
    io.sel_valid = 1'b1;
    io.select    = 5'd24;
    step();
    check_bus("explicit24", 32'hA000_0018, 1'b1, onehot(24), 5'd24);
    io.select = 5'd25;
    step();
    check_bus("sel25", 32'hA000_0018, 1'b0, '0, 5'd24);
    check("sel25.sel_err", 64'(io.sel_err), 64'd1);

    // Round robin: rr_ptr is still 1 from the post-reset grant.
    io.sel_valid = 1'b0;
    io.mode      = 1'b1;
    io.req       = onehot(3) | onehot(10) | onehot(24);
    step();
    check_bus("rr0", 32'hA000_0003, 1'b1, onehot(3), 5'd3);
    check("rr0.sel_err", 64'(io.sel_err), 64'd0);
    step();
    check_bus("rr1", 32'hA000_000A, 1'b1, onehot(10), 5'd10);
    step();
    check_bus("rr2", 32'hA000_0018, 1'b1, onehot(24), 5'd24);
    step();
    check_bus("rr3_wrap", 32'hA000_0003, 1'b1, onehot(3), 5'd3);
    step();
    check_bus("rr4", 32'hA000_000A, 1'b1, onehot(10), 5'd10);

    // Lock: owner 10 keeps the bus and it tracks live data.
    io.lock = 1'b1;
    set_word(10, 32'd5);
    step();
    check_bus("lock5", 32'd5, 1'b1, onehot(10), 5'd10);
    set_word(10, 32'd6);
    step();
    check_bus("lock6", 32'd6, 1'b1, onehot(10), 5'd10);
    io.req[10] = 1'b0;
    step();
    check_bus("lock_drop", 32'hA000_0018, 1'b1, onehot(24), 5'd24);
    step();
    check_bus("lock_hold24", 32'hA000_0018, 1'b1, onehot(24), 5'd24);

    // Reset while 24 owns the bus under lock; arbitration restarts from 0.
    clr = 1'b1;
    step();
    check_bus("midlock_reset", 32'h0, 1'b0, '0, 5'd0);
    check("midlock_reset.state", 64'(state_dbg), 64'd0);
    clr = 1'b0;
    step();
    check_bus("after_reset", 32'hA000_0003, 1'b1, onehot(3), 5'd3);

    // No requests: bus and index hold, no grant.
    io.req  = '0;
    io.lock = 1'b0;
    step();
    check_bus("idle", 32'hA000_0003, 1'b0, '0, 5'd3);
    check("idle.state", 64'(state_dbg), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
